// File: rtl/puzzle_sequencer_pkg.sv
// Shared types and constants for the puzzle sequencer and its character FIFO.
package puzzle_pkg;

   localparam int CHAR_WIDTH   = 8;
   localparam int RESULT_WIDTH = 16;
   // A FIFO entry is the character plus its end-of-job flag in the top bit.
   localparam int ENTRY_WIDTH  = CHAR_WIDTH + 1;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      STREAM,
      DRAIN,
      DONE
   } seq_state_t;

   // A job is in progress from the solver clear until the result is latched.
   function automatic logic state_is_busy(seq_state_t s);
      return (s == CLEAR) || (s == STREAM) || (s == DRAIN);
   endfunction

endpackage

// File: rtl/puzzle_sequencer_if.sv
// Byte source handshake: the source drives the character, the sequencer answers with ready.
interface puzzle_sequencer_if;
   import puzzle_pkg::*;

   logic [CHAR_WIDTH-1:0] in_char;
   logic                  in_valid;
   logic                  in_last;
   logic                  in_ready;

   modport master (output in_char, output in_valid, output in_last, input in_ready);
   modport slave  (input in_char, input in_valid, input in_last, output in_ready);

endinterface

// File: rtl/puzzle_sequencer_fifo.sv
// Small synchronous FIFO holding {last, char} entries between the source and the solver.
module char_fifo
   import puzzle_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [ENTRY_WIDTH-1:0] din,
   output logic                   full,
   output logic                   empty,
   output logic [ENTRY_WIDTH-1:0] dout
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(DEPTH - 1);

   logic [ENTRY_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [CNT_W-1:0]       count;
   logic                   do_push;
   logic                   do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointers wrap by masking to the power-of-two depth; flush empties the buffer in one cycle.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= (wr_ptr + PTR_W'(1)) & PTR_MASK;
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr + PTR_W'(1)) & PTR_MASK;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array carries no reset; the pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/puzzle_sequencer.sv
// Job controller: clears the solver, streams buffered characters, waits out the drain and latches the result.
module puzzle_sequencer #(
   parameter int FIFO_DEPTH   = 4,
   parameter int DRAIN_CYCLES = 2,
   parameter int RESULT_WIDTH = puzzle_pkg::RESULT_WIDTH
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   puzzle_sequencer_if.slave                src,
   output logic [puzzle_pkg::CHAR_WIDTH-1:0] solver_character,
   output logic                             solver_enable,
   output logic                             solver_rst,
   input  logic [RESULT_WIDTH-1:0]          solver_result,
   output logic [RESULT_WIDTH-1:0]          result,
   output logic                             done,
   output logic                             busy
);
   import puzzle_pkg::*;

   localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

   seq_state_t             state;
   logic [DRAIN_W-1:0]     drain_cnt;
   logic                   last_accepted;
   logic                   fifo_push;
   logic                   fifo_pop;
   logic                   fifo_flush;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [ENTRY_WIDTH-1:0] fifo_dout;

   // Once the final character is in, stop accepting so the next job's bytes stay with the source.
   assign src.in_ready = (state == STREAM) && !fifo_full && !last_accepted;
   assign fifo_push    = src.in_valid && src.in_ready;
   assign fifo_pop     = (state == STREAM) && !fifo_empty;
   assign fifo_flush   = (state == CLEAR);
   assign busy         = state_is_busy(state);
   assign solver_rst   = rst || (state == CLEAR);

   char_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (fifo_flush),
      .din   ({src.in_last, src.in_char}),
      .full  (fifo_full),
      .empty (fifo_empty),
      .dout  (fifo_dout)
   );

   // Job FSM with registered solver outputs, drain countdown and result latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         drain_cnt        <= '0;
         last_accepted    <= 1'b0;
         solver_character <= '0;
         solver_enable    <= 1'b0;
         result           <= '0;
         done             <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               solver_enable <= 1'b0;
               if (start) begin
                  state <= CLEAR;
               end
            end
            CLEAR: begin
               done          <= 1'b0;
               last_accepted <= 1'b0;
               solver_enable <= 1'b0;
               state         <= STREAM;
            end
            STREAM: begin
               if (fifo_push && src.in_last) begin
                  last_accepted <= 1'b1;
               end
               if (fifo_pop) begin
                  solver_character <= fifo_dout[CHAR_WIDTH-1:0];
                  solver_enable    <= 1'b1;
                  if (fifo_dout[CHAR_WIDTH]) begin
                     drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
                     state     <= DRAIN;
                  end
               end else begin
                  solver_enable <= 1'b0;
               end
            end
            DRAIN: begin
               solver_enable <= 1'b0;
               if (drain_cnt == '0) begin
                  result <= solver_result;
                  done   <= 1'b1;
                  state  <= DONE;
               end else begin
                  drain_cnt <= drain_cnt - DRAIN_W'(1);
               end
            end
            DONE: begin
               if (start) begin
                  done  <= 1'b0;
                  state <= CLEAR;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/puzzle_sequencer.md
# puzzle_sequencer

Job controller sitting between a byte source and one puzzle solver datapath (the `assignment*` class: `result`, `character[7:0]`, `enable_character`, `clk`, `rst`).

- Starts a job and soft-resets the solver.
- Buffers incoming characters behind a valid/ready handshake and streams them one per cycle on the solver's `character`/`enable_character` inputs.
- After the final character, waits a fixed drain interval, latches the solver result and raises `done`.
- Replaces the hand-sequenced stimulus loop with a reusable, synthesizable front end.

## Interface

Parameters:
- `FIFO_DEPTH`, 4: character buffer entries; power of two, ≥2.
- `DRAIN_CYCLES`, 2: idle cycles between the last enabled character and result capture; ≥1.
- `RESULT_WIDTH`, 16: width of the solver result.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a job; honoured only in IDLE or DONE.
- `in_char` in 8: character from the source.
- `in_valid` in 1: `in_char` is valid.
- `in_last` in 1: qualifies `in_char` as the final character of the job.
- `in_ready` out 1: sequencer accepts `in_char` this cycle.
- `solver_character` out 8: character to the solver.
- `solver_enable` out 1: `solver_character` is valid this cycle.
- `solver_rst` out 1: solver reset.
- `solver_result` in RESULT_WIDTH: solver output.
- `result` out RESULT_WIDTH: latched job result.
- `done` out 1: `result` is valid.
- `busy` out 1: job in progress (CLEAR, STREAM or DRAIN).

## Operation

FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.

- **IDLE**
  - `in_ready`=0, `busy`=0, `done`=0.
  - `start` → CLEAR.
- **CLEAR** (exactly 1 cycle)
  - `solver_rst`=1; FIFO flushed; `done` cleared; `result` retained.
  - → STREAM.
- **STREAM**
  - `in_ready` = FIFO not full and final character not yet accepted.
  - Push on `in_valid && in_ready`: stores {`in_last`, `in_char`}.
  - Every cycle with FIFO non-empty: pop head onto registered `solver_character` with `solver_enable`=1. Otherwise `solver_enable`=0 and `solver_character` holds its value.
  - Popping an entry with the last flag → DRAIN; drain counter loaded with DRAIN_CYCLES.
  - Push and pop in the same cycle are both allowed; the full test uses the pre-pop count.
- **DRAIN**
  - `solver_enable`=0, `in_ready`=0; counter decrements.
  - At the end of the final drain cycle, `result` ← `solver_result`; → DONE.
- **DONE**
  - `done`=1, `busy`=0, `in_ready`=0.
  - `start` → CLEAR, and `done` drops that edge.

Boundary conditions:
- `start` in CLEAR, STREAM or DRAIN: ignored.
- `in_valid` while `in_ready`=0: not accepted; the source holds the data.
- Zero-length jobs are not supported; every job ends with one `in_last` character.
- Characters are passed as raw bytes; no filtering (newlines included).
- `rst` mid-job: next edge → IDLE, FIFO empty, all outputs at reset values. A partially streamed job is discarded.

## Timing

Reset values:
- `in_ready`=0, `solver_character`=0, `solver_enable`=0, `result`=0, `done`=0, `busy`=0.
- `solver_rst`=1 while `rst` is high (`solver_rst` = `rst` OR state==CLEAR).

Latency and throughput:
- `start` sampled at edge k: CLEAR during cycle k+1; STREAM and `in_ready` (FIFO empty) from cycle k+2.
- Character accepted at edge n into an empty FIFO: `solver_enable`=1 with that character during cycle n+1 → n+2. Minimum latency 1 cycle.
- Sustained throughput: 1 character/cycle; no bubbles while the source keeps `in_valid` high.
- Last character enabled in cycle L: `solver_enable`=0 for cycles L+1 … L+DRAIN_CYCLES. `result` captured at the end of cycle L+DRAIN_CYCLES; `done`=1 from cycle L+DRAIN_CYCLES+1.

## Structure

- Shared package `puzzle_pkg`:
  - state enum `seq_state_t`
  - `CHAR_WIDTH`=8
  - default `RESULT_WIDTH`=16
- Sub-module `char_fifo`:
  - synchronous FIFO, parameter `DEPTH`, 9-bit entries ({last, char}).
  - Ports: `push`, `pop`, `flush`, `full`, `empty`, `dout`.
  - Pointer wrap-around by power-of-two masking; occupancy counter of width $clog2(DEPTH)+1.
- `puzzle_sequencer` holds the FSM, drain counter, output registers and result latch.

## Test plan

1. **Reset:** `rst`=1 for 2 cycles → `solver_rst`=1, all other outputs 0. After release the FSM stays in IDLE (`in_ready`=0).
2. **Short job, stub solver echoing an enabled-character count:** `start`, then "ab\n" with `in_last` on '\n', `in_valid` held high → `solver_enable` high 3 consecutive cycles starting 1 cycle after first acceptance; `result`=3 and `done`=1 exactly DRAIN_CYCLES+1 cycles after the last enable.
3. **Backpressure:** source pushes 10 bytes while the solver consumes normally → `in_ready` never deasserts. Then force a 4-cycle source stall mid-stream → `solver_enable` gaps are exactly the FIFO-empty cycles; no byte lost or duplicated (stub checksum 10 bytes).
4. **Full FIFO with a stalled sequencer (DRAIN_CYCLES=4, FIFO_DEPTH=4):** hold `start` high in DRAIN → ignored; state, `busy` and counters unaffected.
5. **Mid-job reset:** `rst` pulsed after 5 of 8 bytes → next cycle IDLE, `in_ready`=0, `result`=0. A fresh job of 2 bytes yields `result`=2.
6. **Back-to-back jobs:** `start` in DONE → `done` falls at that edge, `solver_rst` pulses 1 cycle, and the second job's result is independent of the first (3 then 5).
